// File: rtl/spi_pkg.sv
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the SPI transaction scheduler: default
//               sizes, FSM state encoding and the round-robin pick helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int c_nreq_default = 4;
    localparam int c_dw_default   = 8;
    localparam int c_lenw_default = 4;
    localparam int c_gap_default  = 2;

    // Upper bound on requesters the pick helper can handle.
    localparam int c_max_req = 32;

    // Scheduler FSM encoding.
    localparam int         c_st_w     = 3;
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_setup = 3'd1;
    localparam logic [2:0] c_st_issue = 3'd2;
    localparam logic [2:0] c_st_wait  = 3'd3;
    localparam logic [2:0] c_st_hold  = 3'd4;
    localparam logic [2:0] c_st_gapw  = 3'd5;

    // First set request at or above ptr, wrapping modulo n, as a one-hot.
    function automatic logic [c_max_req-1:0] rr_pick(
        input logic [c_max_req-1:0] req,
        input logic [4:0]           ptr,
        input int unsigned          n
    );
        logic [c_max_req-1:0] pick;
        logic                 found;
        logic [4:0]           idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < c_max_req; k++) begin
            if (!found && (k < n)) begin
                idx = 5'((32'(ptr) + k) % n);
                if (req[idx]) begin
                    pick[idx] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_rr_arbiter.sv
// ============================================================================
// Module      : spi_rr_arbiter
// Description : Combinational round-robin arbiter; request vector plus
//               priority pointer in, one-hot winner out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_rr_arbiter
    import spi_pkg::*;
#(
    parameter int NREQ = c_nreq_default,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic [c_max_req-1:0] w_req_ext;
    logic [c_max_req-1:0] w_pick;
    logic                 w_unused_pick;

    assign w_req_ext     = c_max_req'(req);
    assign w_pick        = rr_pick(w_req_ext, 5'(ptr), NREQ);
    assign gnt           = w_pick[NREQ-1:0];
    // Bits above NREQ are always zero.
    assign w_unused_pick = ^w_pick;

endmodule

`default_nettype wire

// File: rtl/spi_txn_scheduler.sv
// ============================================================================
// Module      : spi_txn_scheduler
// Description : Shares one SPI shift engine between NREQ requesters. Picks a
//               burst round-robin, drives the winner's chip-select, feeds
//               bytes to the engine one at a time and enforces an idle gap
//               between frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_txn_scheduler
    import spi_pkg::*;
#(
    parameter int NREQ = c_nreq_default,
    parameter int DW   = c_dw_default,
    parameter int LENW = c_lenw_default,
    parameter int GAP  = c_gap_default
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] req_len,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      req_done,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic                 eng_start,
    output logic [DW-1:0]        eng_data,
    input  logic                 eng_done,
    output logic [NREQ-1:0]      cs_n
);

    localparam int c_pw = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_gw = (GAP > 1) ? $clog2(GAP) : 1;

    logic [c_st_w-1:0] r_state;
    logic [c_pw-1:0]   r_ptr;
    logic [c_pw-1:0]   r_idx;
    logic [LENW-1:0]   r_rem;
    logic [c_gw-1:0]   r_gap_cnt;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   r_req_ack;
    logic [NREQ-1:0]   r_req_done;
    logic [NREQ-1:0]   r_cs_n;
    logic              r_eng_start;
    logic [DW-1:0]     r_eng_data;

    logic [NREQ-1:0]   w_pick;
    logic [c_pw-1:0]   w_pick_idx;
    logic [LENW-1:0]   w_pick_len;
    logic [DW-1:0]     w_cur_data;

    spi_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (c_pw)
    ) u_arb (
        .req (req),
        .ptr (r_ptr),
        .gnt (w_pick)
    );

    // Decode the arbiter winner's index and burst length.
    always_comb begin
        w_pick_idx = '0;
        w_pick_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick[i]) begin
                w_pick_idx = c_pw'(i);
                w_pick_len = req_len[i*LENW +: LENW];
            end
        end
    end

    // Current byte of the requester that owns the frame.
    always_comb begin
        w_cur_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_idx == c_pw'(i)) begin
                w_cur_data = req_data[i*DW +: DW];
            end
        end
    end

    // Frame sequencer: arbitration, CS control, byte issue and gap timing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_st_idle;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_rem       <= '0;
            r_gap_cnt   <= '0;
            r_grant     <= '0;
            r_req_ack   <= '0;
            r_req_done  <= '0;
            r_cs_n      <= '1;
            r_eng_start <= 1'b0;
            r_eng_data  <= '0;
        end else begin
            r_req_ack   <= '0;
            r_req_done  <= '0;
            r_eng_start <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_grant <= '0;
                    if (|req) begin
                        r_grant <= w_pick;
                        r_idx   <= w_pick_idx;
                        r_rem   <= w_pick_len;
                        if (w_pick_len == '0) begin
                            // Empty burst: report it and stay idle; the
                            // pointer is not advanced.
                            r_req_done <= w_pick;
                        end else begin
                            r_cs_n  <= ~w_pick;
                            r_state <= c_st_setup;
                        end
                    end
                end
                c_st_setup: begin
                    r_state <= c_st_issue;
                end
                c_st_issue: begin
                    r_eng_start <= 1'b1;
                    r_eng_data  <= w_cur_data;
                    r_req_ack   <= r_grant;
                    r_state     <= c_st_wait;
                end
                c_st_wait: begin
                    if (eng_done) begin
                        if (r_rem == LENW'(1)) begin
                            r_state <= c_st_hold;
                        end else begin
                            r_rem   <= r_rem - 1'b1;
                            r_state <= c_st_issue;
                        end
                    end
                end
                c_st_hold: begin
                    r_cs_n     <= '1;
                    r_req_done <= r_grant;
                    r_grant    <= '0;
                    r_ptr      <= (r_idx == c_pw'(NREQ - 1)) ? '0 : r_idx + 1'b1;
                    r_gap_cnt  <= '0;
                    r_state    <= c_st_gapw;
                end
                c_st_gapw: begin
                    if (r_gap_cnt == c_gw'(GAP - 1)) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_grant <= '0;
                    r_cs_n  <= '1;
                end
            endcase
        end
    end

    assign req_ack   = r_req_ack;
    assign req_done  = r_req_done;
    assign grant     = r_grant;
    assign busy      = (r_state != c_st_idle);
    assign eng_start = r_eng_start;
    assign eng_data  = r_eng_data;
    assign cs_n      = r_cs_n;

endmodule

`default_nettype wire

// File: tb/tb_spi_txn_scheduler.sv
// ============================================================================
// Module      : tb_spi_txn_scheduler
// Description : Self-checking bench for spi_txn_scheduler with a behavioural
//               shift-engine responder and a queue-based scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_txn_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int LENW = 4;
    localparam int GAP  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*LENW-1:0] req_len = '0;
    logic [NREQ*DW-1:0]   req_data = '0;
    logic                 eng_done = 1'b0;
    logic [NREQ-1:0]      req_ack;
    logic [NREQ-1:0]      req_done;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 eng_start;
    logic [DW-1:0]        eng_data;
    logic [NREQ-1:0]      cs_n;

    always #5 clk = ~clk;

    spi_txn_scheduler #(
        .NREQ (NREQ), .DW (DW), .LENW (LENW), .GAP (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_len   (req_len),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .req_done  (req_done),
        .grant     (grant),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_data  (eng_data),
        .eng_done  (eng_done),
        .cs_n      (cs_n)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Scoreboard queues, filled when stimulus is set up.
    int exp_data[$];
    int exp_ack[$];
    int exp_done[$];
    int exp_grant[$];

    logic [7:0] bytes [4][16];
    logic [3:0] pos [4];
    int         frames_left [4];
    bit         drop_on_ack [4];
    int         cs_low_cnt [4];

    bit         eng_auto = 1'b0;
    int         eng_delay = 3;
    int         eng_cnt = -1;

    logic [3:0] last_grant = '0;
    logic [3:0] last_cs = '1;
    int         hi_run = 0;
    int         gap_seen = 0;
    bit         gap_valid = 1'b0;
    bit         had_frame = 1'b0;
    bit         cs_fell = 1'b0;
    bit         len0_mode = 1'b0;
    bit         exact_gap = 1'b0;
    int         t_grant = -1;
    int         t_start = -1;

    task automatic drive_data();
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = bytes[i][pos[i]];
    endtask

    // Advance one clock; model the engine and the requesters' FIFOs.
    task automatic tick();
        last_grant = grant;
        last_cs    = cs_n;
        @(posedge clk);
        #1;
        cyc++;
        cs_fell   = (cs_n != 4'hF) && (last_cs == 4'hF);
        gap_seen  = hi_run;
        gap_valid = had_frame;
        if (cs_fell) begin
            had_frame = 1'b1;
            for (int i = 0; i < 4; i++) if (!cs_n[i]) cs_low_cnt[i]++;
        end
        hi_run = (cs_n == 4'hF) ? hi_run + 1 : 0;
        eng_done = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_done = 1'b1;
                eng_cnt  = -1;
            end
        end
        if (eng_auto && eng_start) eng_cnt = eng_delay;
        for (int i = 0; i < 4; i++) begin
            if (req_ack[i]) begin
                pos[i] = pos[i] + 4'd1;
                if (drop_on_ack[i]) req[i] = 1'b0;
            end
            if (req_done[i]) begin
                if (frames_left[i] > 0) frames_left[i]--;
                if (frames_left[i] == 0) req[i] = 1'b0;
            end
        end
        drive_data();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        eng_done = 1'b0;
        eng_cnt = -1;
        exp_data.delete(); exp_ack.delete(); exp_done.delete(); exp_grant.delete();
        for (int i = 0; i < 4; i++) begin
            pos[i] = '0; frames_left[i] = 0; drop_on_ack[i] = 1'b0; cs_low_cnt[i] = 0;
        end
        had_frame = 1'b0; hi_run = 0; len0_mode = 1'b0; exact_gap = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive_data();
    endtask

    // Scoreboard consumer: compares every DUT event until the queues drain.
    task automatic run_until_idle(input string name, input int budget);
        int  n = 0;
        int  v;
        bit  fin = 1'b0;
        while (!fin) begin
            tick();
            n++;
            checks++;
            if (($countones(grant) > 1) || ((~cs_n & ~grant) != 4'h0)) begin
                failures++;
                $display("FAIL %s invariant cyc=%0d grant=%b cs_n=%b", name, cyc, grant, cs_n);
            end
            if (len0_mode) begin
                checks++;
                if (cs_n !== 4'hF) begin
                    failures++;
                    $display("FAIL %s cs_len0 got=%b exp=1111", name, cs_n);
                end
            end else if (grant != 4'h0) begin
                checks++;
                if ((cs_n !== ~grant) || (busy !== 1'b1)) begin
                    failures++;
                    $display("FAIL %s cs_frame cs_n=%b busy=%b exp cs_n=%b busy=1", name, cs_n, busy, ~grant);
                end
            end
            if (cs_fell && gap_valid) begin
                checks++;
                if (exact_gap ? (gap_seen != GAP + 1) : (gap_seen < GAP)) begin
                    failures++;
                    $display("FAIL %s gap got=%0d exp=%0d", name, gap_seen, GAP + 1);
                end
            end
            if ((grant != 4'h0) && (grant != last_grant)) begin
                checks++;
                if (t_grant < 0) t_grant = cyc;
                if (exp_grant.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected_grant got=%b", name, grant);
                end else begin
                    v = exp_grant.pop_front();
                    if (grant !== (4'b0001 << v)) begin
                        failures++;
                        $display("FAIL %s grant_order got=%b exp=%b", name, grant, 4'b0001 << v);
                    end
                end
            end
            if (eng_start) begin
                checks++;
                if (t_start < 0) t_start = cyc;
                if (exp_data.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected_eng_start data=%h", name, eng_data);
                end else begin
                    v = exp_data.pop_front();
                    if (eng_data !== 8'(v)) begin
                        failures++;
                        $display("FAIL %s eng_data got=%h exp=%h", name, eng_data, 8'(v));
                    end
                end
            end
            if (req_ack != 4'h0) begin
                checks++;
                if (exp_ack.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected_ack got=%b", name, req_ack);
                end else begin
                    v = exp_ack.pop_front();
                    if (req_ack !== (4'b0001 << v)) begin
                        failures++;
                        $display("FAIL %s req_ack got=%b exp=%b", name, req_ack, 4'b0001 << v);
                    end
                end
            end
            if (req_done != 4'h0) begin
                checks++;
                if (exp_done.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected_done got=%b", name, req_done);
                end else begin
                    v = exp_done.pop_front();
                    if (req_done !== (4'b0001 << v)) begin
                        failures++;
                        $display("FAIL %s req_done got=%b exp=%b", name, req_done, 4'b0001 << v);
                    end
                end
            end
            if ((exp_data.size() == 0) && (exp_ack.size() == 0) && (exp_done.size() == 0) &&
                (exp_grant.size() == 0) && !busy && (grant == 4'h0) && (req == 4'h0)) begin
                fin = 1'b1;
            end else if (n >= budget) begin
                checks++;
                failures++;
                $display("FAIL %s timeout left data=%0d ack=%0d done=%0d grant=%0d busy=%b",
                         name, exp_data.size(), exp_ack.size(), exp_done.size(), exp_grant.size(), busy);
                fin = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 7;
        if (grant !== 4'h0)     begin failures++; $display("FAIL reset grant got=%b exp=0000", grant); end
        if (req_ack !== 4'h0)   begin failures++; $display("FAIL reset req_ack got=%b exp=0000", req_ack); end
        if (req_done !== 4'h0)  begin failures++; $display("FAIL reset req_done got=%b exp=0000", req_done); end
        if (eng_start !== 1'b0) begin failures++; $display("FAIL reset eng_start got=%b exp=0", eng_start); end
        if (eng_data !== 8'h00) begin failures++; $display("FAIL reset eng_data got=%h exp=00", eng_data); end
        if (busy !== 1'b0)      begin failures++; $display("FAIL reset busy got=%b exp=0", busy); end
        if (cs_n !== 4'hF)      begin failures++; $display("FAIL reset cs_n got=%b exp=1111", cs_n); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_burst();
        int t0;
        do_reset();
        bytes[1][0] = 8'hA5; bytes[1][1] = 8'h3C; bytes[1][2] = 8'hF0;
        req_len[7:4] = 4'd3;
        frames_left[1] = 1;
        eng_auto = 1'b1; eng_delay = 8;
        exp_grant.push_back(1);
        exp_data.push_back('hA5); exp_data.push_back('h3C); exp_data.push_back('hF0);
        repeat (3) exp_ack.push_back(1);
        exp_done.push_back(1);
        drive_data();
        req[1] = 1'b1;
        t0 = cyc; t_grant = -1; t_start = -1;
        run_until_idle("single", 200);
        checks += 4;
        if (t_grant != t0 + 1)      begin failures++; $display("FAIL single grant_latency got=%0d exp=1", t_grant - t0); end
        if (t_start != t0 + 3)      begin failures++; $display("FAIL single start_latency got=%0d exp=3", t_start - t0); end
        if (cs_low_cnt[1] != 1)     begin failures++; $display("FAIL single cs_frames got=%0d exp=1", cs_low_cnt[1]); end
        if (hi_run != GAP + 1)      begin failures++; $display("FAIL single gap_to_idle got=%0d exp=%0d", hi_run, GAP + 1); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_len = 16'h1111;
        for (int i = 0; i < 4; i++) bytes[i][0] = 8'h10 + 8'(i);
        bytes[0][1] = 8'h50;
        frames_left[0] = 2; frames_left[1] = 1; frames_left[2] = 1; frames_left[3] = 1;
        eng_auto = 1'b1; eng_delay = 3; exact_gap = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_grant.push_back(i); exp_ack.push_back(i); exp_done.push_back(i);
            exp_data.push_back('h10 + i);
        end
        exp_grant.push_back(0); exp_ack.push_back(0); exp_done.push_back(0);
        exp_data.push_back('h50);
        drive_data();
        req = 4'hF;
        run_until_idle("round_robin", 400);
        exact_gap = 1'b0;
        checks += 4;
        if (cs_low_cnt[0] != 2) begin failures++; $display("FAIL rr cs_frames0 got=%0d exp=2", cs_low_cnt[0]); end
        if (cs_low_cnt[1] != 1) begin failures++; $display("FAIL rr cs_frames1 got=%0d exp=1", cs_low_cnt[1]); end
        if (cs_low_cnt[2] != 1) begin failures++; $display("FAIL rr cs_frames2 got=%0d exp=1", cs_low_cnt[2]); end
        if (cs_low_cnt[3] != 1) begin failures++; $display("FAIL rr cs_frames3 got=%0d exp=1", cs_low_cnt[3]); end
    endtask

    task automatic test_len_zero();
        do_reset();
        req_len = 16'h0000;
        frames_left[2] = 1;
        exp_grant.push_back(2); exp_done.push_back(2);
        len0_mode = 1'b1;
        req[2] = 1'b1;
        run_until_idle("len_zero", 50);
        len0_mode = 1'b0;
        // Pointer must still be 0: requester 0 wins over 3.
        req_len[3:0] = 4'd1; req_len[15:12] = 4'd1;
        bytes[0][0] = 8'h61; bytes[3][0] = 8'h64;
        frames_left[0] = 1; frames_left[3] = 1;
        eng_auto = 1'b1; eng_delay = 2;
        exp_grant.push_back(0); exp_grant.push_back(3);
        exp_data.push_back('h61); exp_data.push_back('h64);
        exp_ack.push_back(0); exp_ack.push_back(3);
        exp_done.push_back(0); exp_done.push_back(3);
        drive_data();
        req = 4'b1001;
        run_until_idle("len_zero_ptr", 200);
    endtask

    task automatic test_mid_reset();
        int t0;
        do_reset();
        bytes[0][0] = 8'h11; bytes[0][1] = 8'h22; bytes[0][2] = 8'h33; bytes[0][3] = 8'h44;
        req_len[3:0] = 4'd4;
        eng_auto = 1'b1; eng_delay = 5;
        drive_data();
        req[0] = 1'b1;
        repeat (5) tick();
        checks += 2;
        if (busy !== 1'b1)    begin failures++; $display("FAIL midrst pre_busy got=%b exp=1", busy); end
        if (cs_n !== 4'hE)    begin failures++; $display("FAIL midrst pre_cs got=%b exp=1110", cs_n); end
        #2;
        rst = 1'b0;
        #1;
        checks += 3;
        if (cs_n !== 4'hF)    begin failures++; $display("FAIL midrst cs_n got=%b exp=1111", cs_n); end
        if (grant !== 4'h0)   begin failures++; $display("FAIL midrst grant got=%b exp=0000", grant); end
        if (busy !== 1'b0)    begin failures++; $display("FAIL midrst busy got=%b exp=0", busy); end
        req = '0; eng_cnt = -1; eng_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        pos[0] = '0; bytes[0][0] = 8'h77; req_len[3:0] = 4'd1;
        frames_left[0] = 1; had_frame = 1'b0;
        exp_grant.push_back(0); exp_data.push_back('h77); exp_ack.push_back(0); exp_done.push_back(0);
        drive_data();
        req[0] = 1'b1;
        t0 = cyc; t_grant = -1; t_start = -1;
        run_until_idle("mid_reset", 100);
        checks += 2;
        if (t_grant != t0 + 1) begin failures++; $display("FAIL midrst grant_latency got=%0d exp=1", t_grant - t0); end
        if (t_start != t0 + 3) begin failures++; $display("FAIL midrst start_latency got=%0d exp=3", t_start - t0); end
    endtask

    task automatic test_stray_done();
        eng_done = 1'b1;
        tick();
        checks += 2;
        if (busy !== 1'b0)  begin failures++; $display("FAIL stray idle_busy got=%b exp=0", busy); end
        if (grant !== 4'h0) begin failures++; $display("FAIL stray idle_grant got=%b exp=0000", grant); end
        tick();
        checks++;
        if (busy !== 1'b0)  begin failures++; $display("FAIL stray idle_busy2 got=%b exp=0", busy); end
        pos[1] = '0; bytes[1][0] = 8'h5A; bytes[1][1] = 8'hC3;
        req_len[7:4] = 4'd2; frames_left[1] = 1;
        eng_auto = 1'b1; eng_delay = 3;
        exp_data.push_back('h5A); exp_data.push_back('hC3);
        exp_ack.push_back(1); exp_ack.push_back(1); exp_done.push_back(1);
        drive_data();
        req[1] = 1'b1;
        tick();
        checks += 2;
        if (grant !== 4'b0010) begin failures++; $display("FAIL stray grant got=%b exp=0010", grant); end
        if (cs_n !== 4'b1101)  begin failures++; $display("FAIL stray cs_n got=%b exp=1101", cs_n); end
        eng_done = 1'b1;
        tick();
        checks += 2;
        if (eng_start !== 1'b0) begin failures++; $display("FAIL stray setup_start got=%b exp=0", eng_start); end
        if (busy !== 1'b1)      begin failures++; $display("FAIL stray setup_busy got=%b exp=1", busy); end
        run_until_idle("stray_done", 100);
    endtask

    task automatic test_req_drop();
        pos[3] = '0; bytes[3][0] = 8'h9C; bytes[3][1] = 8'h3E;
        req_len[15:12] = 4'd2; frames_left[3] = 1; drop_on_ack[3] = 1'b1;
        eng_auto = 1'b1; eng_delay = 4;
        exp_grant.push_back(3);
        exp_data.push_back('h9C); exp_data.push_back('h3E);
        exp_ack.push_back(3); exp_ack.push_back(3); exp_done.push_back(3);
        drive_data();
        req[3] = 1'b1;
        run_until_idle("req_drop", 100);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            pos[i] = '0; frames_left[i] = 0; drop_on_ack[i] = 1'b0; cs_low_cnt[i] = 0;
            for (int j = 0; j < 16; j++) bytes[i][j] = '0;
        end
        test_reset();
        test_single_burst();
        test_round_robin();
        test_len_zero();
        test_mid_reset();
        test_stray_done();
        test_req_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_txn_scheduler.md
Name: spi_txn_scheduler

Overview:
- Shares one SPI shift engine between NREQ requesters.
- Arbitrates burst requests round-robin, latches the winner's byte count, drives that requester's chip-select, issues bytes to the engine one at a time and enforces an inter-frame gap.
- Sits between the per-channel input FIFOs (upstream) and the MOSI shift engine (downstream).

Parameters:
- NREQ, 4, number of requesters / chip-selects
- DW, 8, data byte width
- LENW, 4, burst-length field width (1..2^LENW-1 bytes)
- GAP, 2, idle clk cycles with all cs_n high between frames (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- req  in  NREQ  per-requester burst request, level
- req_len  in  NREQ*LENW  burst length per requester, slice i at [i*LENW +: LENW]
- req_data  in  NREQ*DW  current byte per requester, slice i at [i*DW +: DW]
- req_ack  out  NREQ  one-hot pulse: granted requester's current byte taken; present next byte by the following cycle
- req_done  out  NREQ  one-hot pulse: burst finished (or skipped when len=0)
- grant  out  NREQ  one-hot, held for the whole frame
- busy  out  1  high in every state except IDLE
- eng_start  out  1  one-cycle pulse: engine loads eng_data
- eng_data  out  DW  byte to engine, valid with eng_start and held until next issue
- eng_done  in  1  one-cycle pulse from engine: byte shifted out
- cs_n  out  NREQ  active-low chip-selects, at most one low

Behaviour:
- Reset (async, rst=0):
  - state IDLE, rr pointer 0.
  - grant, req_ack, req_done, eng_start all 0; eng_data 0; busy 0.
  - cs_n all 1, forced immediately, including mid-frame.
- States: IDLE, SETUP, ISSUE, WAIT, HOLD, GAPW.
- IDLE:
  - If any req bit is set, select the first set bit searching from rr pointer upward with wrap.
  - Next edge: grant=onehot(i), rem<=req_len[i].
  - If len=0: req_done[i] pulses, grant clears the following cycle, cs untouched, go IDLE.
  - Else: cs_n[i]<=0, go SETUP.
- SETUP: one cycle of CS setup -> ISSUE.
- ISSUE (exactly one cycle):
  - eng_start=1, eng_data<=req_data[i], req_ack[i]=1.
  - -> WAIT.
- WAIT:
  - On eng_done: if rem==1 -> HOLD; else rem<=rem-1 -> ISSUE.
- HOLD: one cycle with CS still low -> GAPW.
- GAPW:
  - cs_n all 1, req_done[i] pulses on entry, grant cleared, rr pointer<=(i+1) mod NREQ.
  - Count GAP cycles, then IDLE.
- Latency: req seen in IDLE to first eng_start is 3 edges (grant/CS, SETUP, ISSUE).
- eng_done outside WAIT is ignored; eng_start never pulses while in WAIT.
- req is sampled only in IDLE. Deasserting req mid-burst does not abort the burst. A requester re-asserting right after done waits for its turn behind any other pending requester.
- rem is LENW bits and never underflows; req_len is ignored after it is latched.
- Invariants: popcount(grant)<=1; cs_n low only for the granted index.

Decomposition:
- Shared package spi_pkg: state encoding enum (IDLE..GAPW), DW/LENW defaults, and a helper function rr_pick(req, ptr) returning a one-hot.
- Sub-module spi_rr_arbiter: combinational request vector + pointer -> one-hot grant. The FSM, counters and CS logic stay in the top level.

Test Plan:
- Single burst: req[1]=1, len=3, data A5/3C/F0, eng_done 8 clk after each eng_start -> cs_n=1101 for the whole frame; 3 eng_start pulses with eng_data A5,3C,F0; 3 req_ack[1] pulses; req_done[1] once; cs_n=1111 for 2 cycles before any new grant.
- Round-robin fairness: req=1111 held, all len=1 -> grant order 0,1,2,3,0; each grant's cs_n low exactly once per frame.
- len=0: req[2]=1, len=0 -> req_done[2] pulse; no eng_start; cs_n stays 1111; rr pointer unchanged.
- Mid-frame reset: rst low during WAIT of a len=4 burst -> cs_n=1111, grant=0, busy=0 immediately; after release, a new req[0] starts from SETUP.
- Stray eng_done: pulse eng_done in IDLE and in SETUP -> no state change, rem unchanged.
- req drop: req[3] deasserted after first req_ack, len=2 -> second byte is still issued and req_done[3] pulses.
